// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: buffers completed MEM instructions in a small FIFO and retires the head
// entry in program order, raising exception/ERTN flushes and exporting forwarding and trace info.
module wb_commit_stage #(
    parameter int                  DATA_W     = 32,
    parameter int                  DEPTH      = 2,
    parameter int                  EXCP_W     = 16,
    parameter logic [6*EXCP_W-1:0] ECODE_MAP  = {EXCP_W{6'h0}},
    parameter int                  CSR_RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ms_to_ws_valid,
    output logic                    ws_allowin,
    input  logic [DATA_W-1:0]       ms_pc,
    input  logic [DATA_W-1:0]       ms_result,
    input  logic [4:0]              ms_dest,
    input  logic                    ms_gr_we,
    input  logic                    ms_res_from_csr,
    input  logic                    ms_ertn,
    input  logic [EXCP_W-1:0]       ms_excp_vec,
    input  logic                    ms_csr_we,
    input  logic [13:0]             ms_csr_num,
    input  logic [DATA_W-1:0]       ms_csr_wmask,
    input  logic [DATA_W-1:0]       ms_csr_wdata,
    output logic [13:0]             csr_rnum,
    input  logic [DATA_W-1:0]       csr_rdata,
    output logic                    csr_we,
    output logic [13:0]             csr_wnum,
    output logic [DATA_W-1:0]       csr_wmask,
    output logic [DATA_W-1:0]       csr_wdata,
    output logic                    excp_flush,
    output logic                    ertn_flush,
    output logic [5:0]              ecode,
    output logic [DATA_W-1:0]       epc,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [DEPTH-1:0]        fwd_valid,
    output logic [DEPTH-1:0]        fwd_gr_we,
    output logic [DEPTH-1:0]        fwd_pending,
    output logic [5*DEPTH-1:0]      fwd_dest,
    output logic [DATA_W*DEPTH-1:0] fwd_data,
    output logic [DATA_W-1:0]       debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [DATA_W-1:0]       debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, CSR_WAIT} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0]  count_q;

    logic [DATA_W-1:0] pcMem_q       [DEPTH];
    logic [DATA_W-1:0] resultMem_q   [DEPTH];
    logic [4:0]        destMem_q     [DEPTH];
    logic              grWeMem_q     [DEPTH];
    logic              resCsrMem_q   [DEPTH];
    logic              ertnMem_q     [DEPTH];
    logic [EXCP_W-1:0] excpMem_q     [DEPTH];
    logic              csrWeMem_q    [DEPTH];
    logic [13:0]       csrNumMem_q   [DEPTH];
    logic [DATA_W-1:0] csrWmaskMem_q [DEPTH];
    logic [DATA_W-1:0] csrWdataMem_q [DEPTH];

    logic headValid, headExcp, needCsrWait;
    logic commit, flush, push;
    logic [5:0] ecodeSel;

    assign headValid   = (count_q != '0);
    assign headExcp    = |excpMem_q[rdPtr_q];
    // Only an exception-free CSR-read head has to wait a cycle for csr_rdata.
    assign needCsrWait = headValid & resCsrMem_q[rdPtr_q] & ~headExcp & (CSR_RD_LAT == 1);

    assign flush      = excp_flush | ertn_flush;
    assign ws_allowin = (count_q != CNT_W'(DEPTH)) & ~flush;
    assign push       = ms_to_ws_valid & ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (needCsrWait) state_d = CSR_WAIT;
            CSR_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Commit side effects are suppressed in a reset cycle, even if a CSR_WAIT was in progress.
    always_comb begin
        commit     = ~reset & headValid & ((state_q == CSR_WAIT) | ~needCsrWait);
        excp_flush = commit & headExcp;
        ertn_flush = commit & ~headExcp & ertnMem_q[rdPtr_q];
        rf_we      = commit & ~headExcp & ~ertnMem_q[rdPtr_q] & grWeMem_q[rdPtr_q];
        csr_we     = commit & ~headExcp & ~ertnMem_q[rdPtr_q] & csrWeMem_q[rdPtr_q];
        rf_waddr   = destMem_q[rdPtr_q];
        rf_wdata   = resCsrMem_q[rdPtr_q] ? csr_rdata : resultMem_q[rdPtr_q];
        csr_rnum   = headValid ? csrNumMem_q[rdPtr_q] : 14'h0;
        csr_wnum   = csrNumMem_q[rdPtr_q];
        csr_wmask  = csrWmaskMem_q[rdPtr_q];
        csr_wdata  = csrWdataMem_q[rdPtr_q];
        ecode      = excp_flush ? ecodeSel : 6'h0;
        epc        = pcMem_q[rdPtr_q];
    end

    // Later iterations override earlier ones, so the highest set bit wins.
    always_comb begin
        ecodeSel = 6'h0;
        for (int i = 0; i < EXCP_W; i++) begin
            if (excpMem_q[rdPtr_q][i]) ecodeSel = ECODE_MAP[6*i +: 6];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
        end else if (flush) begin
            count_q <= '0;
            rdPtr_q <= wrPtr_q;
        end else begin
            if (push)   wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (commit) rdPtr_q <= rdPtr_q + PTR_W'(1);
            if (push & ~commit)      count_q <= count_q + CNT_W'(1);
            else if (~push & commit) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem_q[wrPtr_q]       <= ms_pc;
            resultMem_q[wrPtr_q]   <= ms_result;
            destMem_q[wrPtr_q]     <= ms_dest;
            grWeMem_q[wrPtr_q]     <= ms_gr_we;
            resCsrMem_q[wrPtr_q]   <= ms_res_from_csr;
            ertnMem_q[wrPtr_q]     <= ms_ertn;
            excpMem_q[wrPtr_q]     <= ms_excp_vec;
            csrWeMem_q[wrPtr_q]    <= ms_csr_we;
            csrNumMem_q[wrPtr_q]   <= ms_csr_num;
            csrWmaskMem_q[wrPtr_q] <= ms_csr_wmask;
            csrWdataMem_q[wrPtr_q] <= ms_csr_wdata;
        end
    end

    // Slot k is the k-th oldest entry; pointer arithmetic wraps because DEPTH is a power of two.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             slotValid;
        idx         = '0;
        slotValid   = 1'b0;
        fwd_valid   = '0;
        fwd_gr_we   = '0;
        fwd_pending = '0;
        fwd_dest    = '0;
        fwd_data    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx                          = rdPtr_q + PTR_W'(k);
            slotValid                    = (CNT_W'(k) < count_q);
            fwd_valid[k]                 = slotValid;
            fwd_gr_we[k]                 = slotValid & grWeMem_q[idx] & ~(|excpMem_q[idx]);
            fwd_pending[k]               = slotValid & resCsrMem_q[idx];
            fwd_dest[5*k +: 5]           = destMem_q[idx];
            fwd_data[DATA_W*k +: DATA_W] = resultMem_q[idx];
        end
    end

    assign debug_wb_pc       = pcMem_q[rdPtr_q];
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: a cycle-by-cycle vector table plus hand-written sequences for
// CSR writes, forwarding fields and exception priority.
module tb_wb_commit_stage;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 4;
    localparam int          EXCP_W = 16;
    localparam logic [95:0] MAP    = (96'h3F << 90) | (96'h0B << 60) | (96'h01 << 6);

    logic                    clk;
    logic                    reset;
    logic                    ms_to_ws_valid;
    logic                    ws_allowin;
    logic [DATA_W-1:0]       ms_pc, ms_result;
    logic [4:0]              ms_dest;
    logic                    ms_gr_we, ms_res_from_csr, ms_ertn;
    logic [EXCP_W-1:0]       ms_excp_vec;
    logic                    ms_csr_we;
    logic [13:0]             ms_csr_num;
    logic [DATA_W-1:0]       ms_csr_wmask, ms_csr_wdata;
    logic [13:0]             csr_rnum;
    logic [DATA_W-1:0]       csr_rdata;
    logic                    csr_we;
    logic [13:0]             csr_wnum;
    logic [DATA_W-1:0]       csr_wmask, csr_wdata;
    logic                    excp_flush, ertn_flush;
    logic [5:0]              ecode;
    logic [DATA_W-1:0]       epc;
    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;
    logic [DEPTH-1:0]        fwd_valid, fwd_gr_we, fwd_pending;
    logic [5*DEPTH-1:0]      fwd_dest;
    logic [DATA_W*DEPTH-1:0] fwd_data;
    logic [DATA_W-1:0]       debug_wb_pc;
    logic [3:0]              debug_wb_rf_we;
    logic [4:0]              debug_wb_rf_wnum;
    logic [DATA_W-1:0]       debug_wb_rf_wdata;

    wb_commit_stage #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .EXCP_W(EXCP_W), .ECODE_MAP(MAP), .CSR_RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_res_from_csr(ms_res_from_csr), .ms_ertn(ms_ertn), .ms_excp_vec(ms_excp_vec),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
        .ms_csr_wmask(ms_csr_wmask), .ms_csr_wdata(ms_csr_wdata),
        .csr_rnum(csr_rnum), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode), .epc(epc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_gr_we(fwd_gr_we), .fwd_pending(fwd_pending),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // One record per clock cycle: the inputs driven in that cycle and the outputs expected before its edge.
    typedef struct {
        logic        rst, v;
        logic [31:0] pc, res;
        logic [4:0]  dest;
        logic        gwe, rcsr, ertn;
        logic [15:0] excp;
        logic [31:0] rdata;
        logic        chkAux, eAllow, eRfWe;
        logic [4:0]  eWaddr;
        logic [31:0] eWdata, ePc;
        logic        eXfl, eEfl;
        logic [5:0]  eEcode;
        logic [3:0]  eFv, eFp;
    } vec_t;

    vec_t vecs[48];
    int   nVec;
    int   passCount;
    int   totalCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic vin(input logic [31:0] rst, v, pc, res, dest, gwe, rcsr, ertn, excp, rdata);
        vecs[nVec].rst    = 1'(rst);
        vecs[nVec].v      = 1'(v);
        vecs[nVec].pc     = pc;
        vecs[nVec].res    = res;
        vecs[nVec].dest   = 5'(dest);
        vecs[nVec].gwe    = 1'(gwe);
        vecs[nVec].rcsr   = 1'(rcsr);
        vecs[nVec].ertn   = 1'(ertn);
        vecs[nVec].excp   = 16'(excp);
        vecs[nVec].rdata  = rdata;
        vecs[nVec].chkAux = ~1'(rst);
    endtask

    task automatic vout(input logic [31:0] allow, rfwe, waddr, wdata, pc, xfl, efl, ec, fv, fp);
        vecs[nVec].eAllow = 1'(allow);
        vecs[nVec].eRfWe  = 1'(rfwe);
        vecs[nVec].eWaddr = 5'(waddr);
        vecs[nVec].eWdata = wdata;
        vecs[nVec].ePc    = pc;
        vecs[nVec].eXfl   = 1'(xfl);
        vecs[nVec].eEfl   = 1'(efl);
        vecs[nVec].eEcode = 6'(ec);
        vecs[nVec].eFv    = 4'(fv);
        vecs[nVec].eFp    = 4'(fp);
        nVec++;
    endtask

    task automatic driveIdle();
        ms_to_ws_valid  = 1'b0;
        ms_pc           = '0;
        ms_result       = '0;
        ms_dest         = '0;
        ms_gr_we        = 1'b0;
        ms_res_from_csr = 1'b0;
        ms_ertn         = 1'b0;
        ms_excp_vec     = '0;
        ms_csr_we       = 1'b0;
        ms_csr_num      = '0;
        ms_csr_wmask    = '0;
        ms_csr_wdata    = '0;
        csr_rdata       = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset           = v.rst;
        ms_to_ws_valid  = v.v;
        ms_pc           = v.pc;
        ms_result       = v.res;
        ms_dest         = v.dest;
        ms_gr_we        = v.gwe;
        ms_res_from_csr = v.rcsr;
        ms_ertn         = v.ertn;
        ms_excp_vec     = v.excp;
        ms_csr_we       = 1'b0;
        ms_csr_num      = v.pc[15:2];
        ms_csr_wmask    = '1;
        ms_csr_wdata    = v.res;
        csr_rdata       = v.rdata;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.chkAux) begin
            cmp({tag, ".allowin"}, 32'(ws_allowin), 32'(v.eAllow));
            cmp({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(v.eFv));
            cmp({tag, ".fwd_pending"}, 32'(fwd_pending), 32'(v.eFp));
        end
        cmp({tag, ".rf_we"}, 32'(rf_we), 32'(v.eRfWe));
        cmp({tag, ".excp_flush"}, 32'(excp_flush), 32'(v.eXfl));
        cmp({tag, ".ertn_flush"}, 32'(ertn_flush), 32'(v.eEfl));
        cmp({tag, ".csr_we"}, 32'(csr_we), 32'h0);
        cmp({tag, ".dbg_rf_we"}, 32'(debug_wb_rf_we), 32'({4{v.eRfWe}}));
        if (v.eRfWe) begin
            cmp({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(v.eWaddr));
            cmp({tag, ".rf_wdata"}, rf_wdata, v.eWdata);
            cmp({tag, ".dbg_pc"}, debug_wb_pc, v.ePc);
            cmp({tag, ".dbg_wnum"}, 32'(debug_wb_rf_wnum), 32'(v.eWaddr));
            cmp({tag, ".dbg_wdata"}, debug_wb_rf_wdata, v.eWdata);
        end
        if (v.eXfl) begin
            cmp({tag, ".ecode"}, 32'(ecode), 32'(v.eEcode));
            cmp({tag, ".epc"}, epc, v.ePc);
        end
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        nVec       = 0;
        reset      = 1'b1;
        driveIdle();
        repeat (2) @(negedge clk);

        // Reset state
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        // Back-to-back commits, one per cycle, one cycle after each push
        vin(0,1,'h100,'h11,1,1,0,0,0,0);                   vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,1,'h104,'h22,2,1,0,0,0,0);                   vout(1,1,1,'h11,'h100,0,0,0,1,0);
        vin(0,1,'h108,'h33,3,1,0,0,0,0);                   vout(1,1,2,'h22,'h104,0,0,0,1,0);
        vin(0,1,'h10C,'h44,4,1,0,0,0,0);                   vout(1,1,3,'h33,'h108,0,0,0,1,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,1,4,'h44,'h10C,0,0,0,1,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        // Chain of CSR-read heads fills the FIFO; the offer at full is held until a pop frees a slot
        vin(0,1,'h200,0,11,1,1,0,0,0);                     vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,1,'h204,0,12,1,1,0,0,0);                     vout(1,0,0,0,0,0,0,0,1,1);
        vin(0,1,'h208,0,13,1,1,0,0,'hDEADBEEF);            vout(1,1,11,'hDEADBEEF,'h200,0,0,0,3,3);
        vin(0,1,'h20C,0,14,1,1,0,0,'h0BADF00D);            vout(1,0,0,0,0,0,0,0,3,3);
        vin(0,1,'h210,'h55,15,1,0,0,0,'h12345678);         vout(1,1,12,'h12345678,'h204,0,0,0,7,7);
        vin(0,1,'h214,'h66,16,1,0,0,0,0);                  vout(1,0,0,0,0,0,0,0,7,3);
        vin(0,1,'h218,'h77,17,1,0,0,0,'hA5A5A5A5);         vout(0,1,13,'hA5A5A5A5,'h208,0,0,0,15,3);
        vin(0,1,'h218,'h77,17,1,0,0,0,0);                  vout(1,0,0,0,0,0,0,0,7,1);
        vin(0,0,0,0,0,0,0,0,0,'hCAFEF00D);                 vout(0,1,14,'hCAFEF00D,'h20C,0,0,0,15,1);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,1,15,'h55,'h210,0,0,0,7,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,1,16,'h66,'h214,0,0,0,3,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,1,17,'h77,'h218,0,0,0,1,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        // Exception head discards the younger buffered entry and refuses the concurrent offer
        vin(0,1,'h300,0,20,1,1,0,0,0);                     vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,1,'h304,'h21,21,1,0,0,'h0400,0);             vout(1,0,0,0,0,0,0,0,1,1);
        vin(0,1,'h308,'h22,22,1,0,0,0,'h00000C0C);         vout(1,1,20,'h0C0C,'h300,0,0,0,3,1);
        vin(0,1,'h30C,'h23,23,1,0,0,0,0);                  vout(0,0,0,0,'h304,1,0,'h0B,3,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        // Highest set exception bit selects the ecode
        vin(0,1,'h400,'h40,1,1,0,0,'h8402,0);              vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(0,0,0,0,'h400,1,0,'h3F,1,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        // ERTN flush, no register write
        vin(0,1,'h500,'h50,2,1,0,1,0,0);                   vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(0,0,0,0,0,0,1,0,1,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        // Reset while the head waits for CSR data with two entries queued
        vin(0,1,'h600,0,24,1,1,0,0,0);                     vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,1,'h604,'h25,25,1,0,0,0,0);                  vout(1,0,0,0,0,0,0,0,1,1);
        vin(1,0,0,0,0,0,0,0,0,'h77777777);                 vout(0,0,0,0,0,0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,0,0);                          vout(1,0,0,0,0,0,0,0,0,0);

        for (int i = 0; i < nVec; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // CSR write commits with its GPR write in the same cycle
        @(negedge clk);
        driveIdle();
        reset          = 1'b0;
        ms_to_ws_valid = 1'b1;
        ms_pc          = 32'h700;
        ms_result      = 32'h88;
        ms_dest        = 5'd8;
        ms_gr_we       = 1'b1;
        ms_csr_we      = 1'b1;
        ms_csr_num     = 14'h006;
        ms_csr_wmask   = 32'h0000FFFF;
        ms_csr_wdata   = 32'h1234;
        @(negedge clk);
        driveIdle();
        ms_to_ws_valid  = 1'b1;
        ms_pc           = 32'h704;
        ms_dest         = 5'd9;
        ms_gr_we        = 1'b1;
        ms_res_from_csr = 1'b1;
        ms_csr_num      = 14'h0AB;
        #1;
        cmp("h.rf_we", 32'(rf_we), 32'h1);
        cmp("h.rf_waddr", 32'(rf_waddr), 32'h8);
        cmp("h.csr_we", 32'(csr_we), 32'h1);
        cmp("h.csr_wnum", 32'(csr_wnum), 32'h006);
        cmp("h.csr_wmask", csr_wmask, 32'h0000FFFF);
        cmp("h.csr_wdata", csr_wdata, 32'h1234);
        // Exception entry queued behind a CSR-read head: csr_rnum and forwarding fields
        @(negedge clk);
        driveIdle();
        ms_to_ws_valid = 1'b1;
        ms_pc          = 32'h708;
        ms_result      = 32'h99;
        ms_dest        = 5'd10;
        ms_gr_we       = 1'b1;
        ms_excp_vec    = 16'h0002;
        ms_csr_we      = 1'b1;
        ms_csr_num     = 14'h007;
        #1;
        cmp("h.csr_rnum", 32'(csr_rnum), 32'h0AB);
        cmp("h.rf_we_wait", 32'(rf_we), 32'h0);
        cmp("h.fwd_pending", 32'(fwd_pending), 32'h1);
        @(negedge clk);
        driveIdle();
        csr_rdata = 32'h5555;
        #1;
        cmp("h.csr_rd_wdata", rf_wdata, 32'h5555);
        cmp("h.fwd_gr_we", 32'(fwd_gr_we), 32'h1);
        cmp("h.fwd_dest1", 32'(fwd_dest[9:5]), 32'd10);
        cmp("h.fwd_data1", fwd_data[63:32], 32'h99);
        @(negedge clk);
        driveIdle();
        #1;
        cmp("h.excp_flush", 32'(excp_flush), 32'h1);
        cmp("h.ecode_bit1", 32'(ecode), 32'h01);
        cmp("h.epc", epc, 32'h708);
        cmp("h.excp_csr_we", 32'(csr_we), 32'h0);
        cmp("h.excp_rf_we", 32'(rf_we), 32'h0);
        @(negedge clk);
        #1;
        cmp("h.post_fwd_valid", 32'(fwd_valid), 32'h0);
        cmp("h.post_allowin", 32'(ws_allowin), 32'h1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Parametrised writeback/commit stage for the LoongArch pipeline, sitting between MEM stage and the register file / CSR unit. It buffers up to DEPTH completed instructions from MEM in a FIFO, retires one per cycle in program order, and raises exception or ERTN flushes from the head entry, discarding younger buffered entries. It supports an optional one-cycle-latency CSR read, exports per-entry forwarding information to ID, and drives the trace debug interface. The CSR register file itself lives outside this block.

## Interface
- DATA_W, 32, GPR/CSR data and PC width
- DEPTH, 2, FIFO entries; power of two, 2..8
- EXCP_W, 16, exception vector width; bit EXCP_W-1 has highest priority
- ECODE_MAP, {EXCP_W{6'h0}}, packed 6-bit ecode per exception bit; bit i at [6i+5:6i]
- CSR_RD_LAT, 1, CSR read latency in cycles; 0 or 1
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM stage offers an instruction
- ws_allowin  out  1  stage can accept this cycle
- ms_pc, ms_result  in  DATA_W each  PC, computed result
- ms_dest  in  5  destination GPR; ms_gr_we in 1 GPR write enable
- ms_res_from_csr, ms_ertn  in  1 each  result comes from CSR read; instruction is ERTN
- ms_excp_vec  in  EXCP_W  pending exception bits (all zero = none)
- ms_csr_we  in  1; ms_csr_num in 14; ms_csr_wmask, ms_csr_wdata in DATA_W each
- csr_rnum  out  14  CSR read address (head entry)
- csr_rdata  in  DATA_W  CSR read data, valid CSR_RD_LAT cycles after csr_rnum
- csr_we  out  1; csr_wnum out 14; csr_wmask, csr_wdata out DATA_W each
- excp_flush, ertn_flush  out  1 each  flush pulses
- ecode  out  6; epc out DATA_W  exception info to CSR unit
- rf_we  out  1; rf_waddr out 5; rf_wdata out DATA_W
- fwd_valid, fwd_gr_we, fwd_pending  out  DEPTH each  per-entry, oldest at bit 0
- fwd_dest  out  5*DEPTH; fwd_data out DATA_W*DEPTH  packed, oldest at lowest slice
- debug_wb_pc out DATA_W; debug_wb_rf_we out 4; debug_wb_rf_wnum out 5; debug_wb_rf_wdata out DATA_W

## Operation
- Storage: DEPTH-entry FIFO, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- ws_allowin = (count != DEPTH) & ~flush, where flush = excp_flush | ertn_flush. Push when ms_to_ws_valid & ws_allowin. A push does not depend on a same-cycle pop.
- Head commit FSM, states IDLE, CSR_WAIT:
  - IDLE, count==0: nothing.
  - IDLE, head has res_from_csr, no exception, CSR_RD_LAT==1: drive csr_rnum, go CSR_WAIT, no pop.
  - IDLE, otherwise (including CSR_RD_LAT==0): commit head this cycle (pop).
  - CSR_WAIT: commit head with rf_wdata = csr_rdata, return IDLE.
- Commit actions:
  - Exception (excp_vec != 0): excp_flush=1, ecode = ECODE_MAP slice of highest set bit, epc = head pc. No rf_we, no csr_we. FIFO emptied (count=0, rd_ptr=wr_ptr).
  - ERTN, no exception: ertn_flush=1, FIFO emptied, no rf_we.
  - Otherwise: rf_we = gr_we; rf_waddr = dest; rf_wdata = csr_rdata if res_from_csr else result. csr_we = head csr_we, same cycle, with num/wmask/wdata.
- csr_rnum = head csr_num whenever count!=0.
- Forwarding: slot k describes the k-th oldest entry; fwd_valid[k] = (k < count). fwd_pending[k] = res_from_csr (data not yet known). Entries with exceptions report fwd_gr_we=0.
- Debug outputs mirror the committed entry; debug_wb_rf_we = {4{rf_we}}.

## Timing
- Reset: count, pointers 0, state IDLE. All flush, rf_we, csr_we, fwd_valid, debug_wb_rf_we outputs 0; ws_allowin 1 in the first cycle after reset.
- Reset mid-operation discards all entries, including a CSR_WAIT in progress; no commit side effects in the reset cycle.
- Push at edge t: entry is head and may commit in cycle t+1 (latency 1). A CSR-read head commits in cycle t+2 when CSR_RD_LAT=1.
- Throughput: 1 commit/cycle for non-CSR-read entries.
- Commit outputs (rf_*, csr_*, flushes, ecode, epc, debug) are combinational from registered head state plus FSM state, valid only in the commit cycle.
- Flush cycle: ws_allowin=0, so a concurrent MEM offer is not accepted. The next cycle starts with count=0.
- Full with simultaneous pop: no push that cycle (allowin was 0).

## Test plan
- Back-to-back: 4 entries, gr_we=1, dest 1..4, results 0x11..0x44 -> rf_we in 4 consecutive cycles starting 1 cycle after the first push, in order.
- Full: DEPTH=2, hold the head by making it a CSR read, push 3 -> ws_allowin=0 after 2 pushes; the third is accepted only after the first pop.
- Exception flush: 3 queued, head excp_vec=16'h0400 with ECODE_MAP bit10=0x0B -> excp_flush=1, ecode=0x0B, epc=head pc, no rf_we, count=0 next cycle, younger two never commit.
- Priority: excp_vec=16'h8402 -> ecode = ECODE_MAP[15] slice.
- CSR read: CSR_RD_LAT=1, head res_from_csr, csr_rdata=0xDEAD_BEEF one cycle after csr_rnum -> rf_wdata=0xDEADBEEF in the second cycle; fwd_pending[0]=1 meanwhile.
- Reset while in CSR_WAIT with 2 queued -> no rf_we or csr_we; all outputs at reset values next cycle.
